// File: rtl/jtkcpu_bus_pkg.sv
// Shared definitions for the jtkcpu bus responder.
//   state_t  : responder FSM encoding (IDLE/WAIT/FETCH/ACK, 2 bits)
//   region_t : address decode result (RAM/ROM/open-bus)
//   OPEN_BUS : value returned to the CPU when no device answers
package jtkcpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FETCH = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_ROM  = 2'd1,
    RGN_OPEN = 2'd2
  } region_t;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/jtkcpu_bus_decode.sv
// Combinational region decode of the 24-bit CPU address.
//   addr : CPU address
//   rgn  : RGN_RAM, RGN_ROM or RGN_OPEN; RAM wins when both regions match
module jtkcpu_bus_decode
  import jtkcpu_bus_pkg::*;
#(
  parameter logic [23:0] RAM_BASE = 24'h000000,
  parameter logic [23:0] RAM_MASK = 24'hFFE000,
  parameter logic [23:0] ROM_BASE = 24'h008000,
  parameter logic [23:0] ROM_MASK = 24'hFF8000
) (
  input  logic [23:0] addr,
  output region_t     rgn
);

  always_comb begin
    rgn = RGN_OPEN;
    if ((addr & ROM_MASK) == ROM_BASE) rgn = RGN_ROM;
    // Checked last so that an overlapping RAM window takes priority.
    if ((addr & RAM_MASK) == RAM_BASE) rgn = RGN_RAM;
  end

endmodule

// File: rtl/jtkcpu_bus_target.sv
// Bus responder opposite the jtkcpu: decodes each access, inserts
// per-region wait states, forwards it to a req/ok backend and acknowledges.
//   clk, rst_n (async, active-low), cen (FSM clock enable)
//   CPU side     : as, we, addr, cpu_dout -> cpu_din, dtack
//   backend side : mem_cs, mem_sel, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ok
//   status       : berr (sticky timeout flag), berr_clr
//
// Handshake: the CPU raises `as` to start an access and keeps it high until
// `dtack`; `dtack` then stays high until `as` is seen low on a cen. A new
// access is accepted only after `as` has been low for one cen in IDLE.
// Backend: `mem_cs` is a request held (with stable sel/we/addr/wdata) until
// the cen on which `mem_ok` (or an `mem_ok` seen on an earlier non-cen clk)
// completes it; `mem_cs` is only ever high in FETCH, so never with `dtack`.
module jtkcpu_bus_target
  import jtkcpu_bus_pkg::*;
#(
  parameter logic [23:0] RAM_BASE = 24'h000000,
  parameter logic [23:0] RAM_MASK = 24'hFFE000,
  parameter logic [23:0] ROM_BASE = 24'h008000,
  parameter logic [23:0] ROM_MASK = 24'hFF8000,
  parameter int unsigned WS_RAM   = 0,
  parameter int unsigned WS_ROM   = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        as,
  input  logic        we,
  input  logic [23:0] addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        dtack,
  output logic        mem_cs,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ok,
  output logic        berr,
  input  logic        berr_clr
);

  localparam logic [7:0] WS_RAM_C = 8'(WS_RAM);
  localparam logic [7:0] WS_ROM_C = 8'(WS_ROM);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  ws_cnt_q, ws_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        pend_q, pend_d;
  logic        armed_q, armed_d;
  logic [7:0]  cpu_din_q, cpu_din_d;
  logic        mem_cs_q, mem_cs_d;
  logic        mem_sel_q, mem_sel_d;
  logic        mem_we_q, mem_we_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        berr_q, berr_d;
  logic        berr_set;
  region_t     rgn_now;

  jtkcpu_bus_decode #(
    .RAM_BASE (RAM_BASE),
    .RAM_MASK (RAM_MASK),
    .ROM_BASE (ROM_BASE),
    .ROM_MASK (ROM_MASK)
  ) u_decode (
    .addr (addr),
    .rgn  (rgn_now)
  );

  always_comb begin
    state_d     = state_q;
    ws_cnt_d    = ws_cnt_q;
    to_cnt_d    = to_cnt_q;
    pend_d      = pend_q;
    armed_d     = armed_q;
    cpu_din_d   = cpu_din_q;
    mem_sel_d   = mem_sel_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    berr_set    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cen) begin
          if (!as) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            armed_d     = 1'b0;
            mem_addr_d  = addr;
            mem_we_d    = we;
            mem_wdata_d = cpu_dout;
            mem_sel_d   = (rgn_now == RGN_ROM);
            to_cnt_d    = 8'd0;
            pend_d      = 1'b0;
            unique case (rgn_now)
              RGN_RAM: begin
                ws_cnt_d = WS_RAM_C;
                state_d  = (WS_RAM_C == 8'd0) ? FETCH : WAIT;
              end
              RGN_ROM: begin
                ws_cnt_d = WS_ROM_C;
                // ROM writes are acknowledged without touching the backend.
                if (WS_ROM_C != 8'd0) state_d = WAIT;
                else if (we)          state_d = ACK;
                else                  state_d = FETCH;
              end
              default: begin
                cpu_din_d = OPEN_BUS;
                state_d   = ACK;
              end
            endcase
          end
        end
      end
      WAIT: begin
        if (cen) begin
          if (!as) begin
            state_d = IDLE;
          end else if (ws_cnt_q <= 8'd1) begin
            ws_cnt_d = 8'd0;
            state_d  = (mem_sel_q && mem_we_q) ? ACK : FETCH;
          end else begin
            ws_cnt_d = ws_cnt_q - 8'd1;
          end
        end
      end
      FETCH: begin
        // mem_ok is watched on every clk so a pulse between cens is not lost.
        if (mem_ok) pend_d = 1'b1;
        if (cen) begin
          pend_d = 1'b0;
          if (!as) begin
            state_d = IDLE;
          end else if (mem_ok || pend_q) begin
            if (!mem_we_q) cpu_din_d = mem_rdata;
            state_d = ACK;
          end else if (to_cnt_q == TO_LAST) begin
            berr_set  = 1'b1;
            cpu_din_d = OPEN_BUS;
            state_d   = ACK;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end
      end
      ACK: begin
        if (cen && !as) state_d = IDLE;
      end
    endcase

    mem_cs_d = (state_d == FETCH);
    berr_d   = berr_set ? 1'b1 : (berr_clr ? 1'b0 : berr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ws_cnt_q    <= 8'd0;
      to_cnt_q    <= 8'd0;
      pend_q      <= 1'b0;
      armed_q     <= 1'b0;
      cpu_din_q   <= OPEN_BUS;
      mem_cs_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 24'd0;
      mem_wdata_q <= 8'd0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_cnt_q    <= ws_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pend_q      <= pend_d;
      armed_q     <= armed_d;
      cpu_din_q   <= cpu_din_d;
      mem_cs_q    <= mem_cs_d;
      mem_sel_q   <= mem_sel_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      berr_q      <= berr_d;
    end
  end

  assign cpu_din   = cpu_din_q;
  assign dtack     = (state_q == ACK);
  assign mem_cs    = mem_cs_q;
  assign mem_sel   = mem_sel_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign berr      = berr_q;

endmodule

// File: tb/tb_jtkcpu_bus_target.sv
// Testbench for jtkcpu_bus_target: scenario tasks plus a randomized run
// checked against a latency/data model derived from the region rules.
module tb_jtkcpu_bus_target;

  localparam int WS_RAM  = 0;
  localparam int WS_ROM  = 1;
  localparam int TIMEOUT = 4;

  logic        clk, rst_n, cen, as, we;
  logic [23:0] addr;
  logic [7:0]  cpu_dout, cpu_din;
  logic        dtack, mem_cs, mem_sel, mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ok, berr, berr_clr;

  int   total, bad;
  logic gap_en;
  logic [7:0] exp_q[$];

  jtkcpu_bus_target #(
    .WS_RAM (WS_RAM),
    .WS_ROM (WS_ROM),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .as(as), .we(we), .addr(addr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .dtack(dtack), .mem_cs(mem_cs),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ok(mem_ok),
    .berr(berr), .berr_clr(berr_clr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // 0 = RAM, 1 = ROM, 2 = open bus
  function automatic int exp_region(input logic [23:0] a);
    if ((a & 24'hFFE000) == 24'h000000) return 0;
    if ((a & 24'hFF8000) == 24'h008000) return 1;
    return 2;
  endfunction

  // Cen index (1 = edge sampling as) after which mem_cs is first seen; -1 never.
  function automatic int exp_cs_cen(input int rg, input logic w);
    if (rg == 2) return -1;
    if (rg == 1) return w ? -1 : 1 + WS_ROM;
    return 1 + WS_RAM;
  endfunction

  function automatic int exp_dtack_cen(input int rg, input logic w, input int ok_after);
    if (rg == 2) return 1;
    if (rg == 1 && w) return 1 + WS_ROM;
    return exp_cs_cen(rg, w) + ok_after + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cen_step();
    int gaps;
    gaps = gap_en ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < gaps; i++) begin
      cen = 1'b0; @(posedge clk); #1;
    end
    cen = 1'b1; @(posedge clk); #1;
    cen = 1'b0;
  endtask

  // Starts an access and plays the backend: mem_ok is offered after mem_cs
  // has been seen ok_after+1 times. Returns observed cen indices.
  task automatic run_access(input logic [23:0] a, input logic w, input logic [7:0] wd,
                            input logic [7:0] rd, input int ok_after, input int max_cens,
                            output int dtack_cen, output int cs_cen, output logic sel_s,
                            output logic [23:0] addr_s, output logic we_s,
                            output logic [7:0] wd_s, output logic overlap);
    int cs_seen;
    dtack_cen = -1; cs_cen = -1; sel_s = 1'b0; addr_s = 24'd0; we_s = 1'b0;
    wd_s = 8'd0; overlap = 1'b0; cs_seen = 0;
    as = 1'b1; addr = a; we = w; cpu_dout = wd; mem_rdata = rd; mem_ok = 1'b0;
    for (int n = 1; n <= max_cens; n++) begin
      cen_step();
      mem_ok = 1'b0;
      if (mem_cs && dtack) overlap = 1'b1;
      if (mem_cs) begin
        if (cs_cen < 0) begin
          cs_cen = n; sel_s = mem_sel; addr_s = mem_addr; we_s = mem_we; wd_s = mem_wdata;
        end
        if (cs_seen == ok_after) mem_ok = 1'b1;
        cs_seen++;
      end
      if (dtack) begin
        dtack_cen = n;
        break;
      end
    end
    mem_ok = 1'b0;
  endtask

  // Drops as: one cen leaves ACK, one more cen in IDLE re-arms.
  task automatic release_bus();
    as = 1'b0; we = 1'b0; mem_ok = 1'b0;
    cen_step();
    cen_step();
  endtask

  // ---------------- tests ----------------
  int dc, cc;
  logic sl, wes, ov;
  logic [23:0] as_s;
  logic [7:0] wds;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (cpu_din !== 8'hFF) begin bad++; $display("FAIL reset_cpu_din got=%h exp=ff", cpu_din); end
    total++; if ({dtack, mem_cs, mem_we, mem_sel, berr} !== 5'b0) begin bad++;
      $display("FAIL reset_flags got=%b exp=00000", {dtack, mem_cs, mem_we, mem_sel, berr}); end
    total++; if ({mem_addr, mem_wdata} !== 32'd0) begin bad++;
      $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata}); end
    @(negedge clk); rst_n = 1'b1;
    release_bus();
  endtask

  task automatic test_ram_read();
    run_access(24'h000123, 1'b0, 8'h00, 8'h5A, 0, 10, dc, cc, sl, as_s, wes, wds, ov);
    total++; if (dc !== exp_dtack_cen(0, 1'b0, 0)) begin bad++; $display("FAIL ram_dtack_cen got=%0d exp=%0d", dc, exp_dtack_cen(0, 1'b0, 0)); end
    total++; if (cpu_din !== 8'h5A) begin bad++; $display("FAIL ram_data got=%h exp=5a", cpu_din); end
    total++; if (cc !== 1 || sl !== 1'b0 || as_s !== 24'h000123) begin bad++;
      $display("FAIL ram_request got cs=%0d sel=%b addr=%h exp cs=1 sel=0 addr=000123", cc, sl, as_s); end
    release_bus();
    total++; if (dtack !== 1'b0) begin bad++; $display("FAIL ram_release got=%b exp=0", dtack); end
  endtask

  task automatic test_rom();
    run_access(24'h00A000, 1'b0, 8'h00, 8'h3C, 1, 10, dc, cc, sl, as_s, wes, wds, ov);
    total++; if (cc !== 2 || sl !== 1'b1) begin bad++; $display("FAIL rom_cs_rise got cs=%0d sel=%b exp cs=2 sel=1", cc, sl); end
    total++; if (dc !== exp_dtack_cen(1, 1'b0, 1) || cpu_din !== 8'h3C) begin bad++;
      $display("FAIL rom_read got dtack=%0d din=%h exp dtack=%0d din=3c", dc, cpu_din, exp_dtack_cen(1, 1'b0, 1)); end
    // Changing addr/we while as stays high must not start anything.
    addr = 24'h000010; we = 1'b1;
    cen_step(); cen_step();
    total++; if (dtack !== 1'b1 || mem_cs !== 1'b0) begin bad++;
      $display("FAIL rom_ack_hold got dtack=%b cs=%b exp dtack=1 cs=0", dtack, mem_cs); end
    release_bus();
    run_access(24'h00A000, 1'b1, 8'h99, 8'h00, 0, 10, dc, cc, sl, as_s, wes, wds, ov);
    total++; if (cc !== -1 || dc !== exp_dtack_cen(1, 1'b1, 0)) begin bad++;
      $display("FAIL rom_write got cs=%0d dtack=%0d exp cs=-1 dtack=%0d", cc, dc, exp_dtack_cen(1, 1'b1, 0)); end
    total++; if (cpu_din !== 8'h3C) begin bad++; $display("FAIL rom_write_din got=%h exp=3c", cpu_din); end
    release_bus();
  endtask

  task automatic test_open_bus();
    run_access(24'h400000, 1'b0, 8'h00, 8'h12, 0, 10, dc, cc, sl, as_s, wes, wds, ov);
    total++; if (dc !== 1 || cc !== -1 || cpu_din !== 8'hFF) begin bad++;
      $display("FAIL open_bus got dtack=%0d cs=%0d din=%h exp dtack=1 cs=-1 din=ff", dc, cc, cpu_din); end
    release_bus();
  endtask

  task automatic test_timeout();
    run_access(24'h000200, 1'b0, 8'h00, 8'h55, 99, 12, dc, cc, sl, as_s, wes, wds, ov);
    total++; if (dc !== 1 + WS_RAM + TIMEOUT || berr !== 1'b1 || cpu_din !== 8'hFF) begin bad++;
      $display("FAIL timeout got dtack=%0d berr=%b din=%h exp dtack=%0d berr=1 din=ff", dc, berr, cpu_din, 1 + WS_RAM + TIMEOUT); end
    release_bus();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL berr_sticky got=%b exp=1", berr); end
    berr_clr = 1'b1; @(posedge clk); #1; berr_clr = 1'b0;
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL berr_clear got=%b exp=0", berr); end
  endtask

  task automatic test_pending();
    as = 1'b1; addr = 24'h000040; we = 1'b0; mem_rdata = 8'h77;
    cen_step();
    total++; if (mem_cs !== 1'b1) begin bad++; $display("FAIL pend_cs got=%b exp=1", mem_cs); end
    cen = 1'b0; mem_ok = 1'b1; @(posedge clk); #1; mem_ok = 1'b0;
    total++; if (dtack !== 1'b0 || mem_cs !== 1'b1) begin bad++;
      $display("FAIL pend_noncen got dtack=%b cs=%b exp dtack=0 cs=1", dtack, mem_cs); end
    cen = 1'b1; @(posedge clk); #1; cen = 1'b0;
    total++; if (dtack !== 1'b1 || cpu_din !== 8'h77 || mem_cs !== 1'b0) begin bad++;
      $display("FAIL pend_done got dtack=%b din=%h cs=%b exp dtack=1 din=77 cs=0", dtack, cpu_din, mem_cs); end
    release_bus();
  endtask

  task automatic test_abort();
    as = 1'b1; addr = 24'h000050; we = 1'b0; mem_rdata = 8'h11;
    cen_step();
    total++; if (mem_cs !== 1'b1) begin bad++; $display("FAIL abort_cs_up got=%b exp=1", mem_cs); end
    as = 1'b0;
    cen = 1'b0; mem_ok = 1'b1; @(posedge clk); #1; mem_ok = 1'b0;
    cen = 1'b1; @(posedge clk); #1; cen = 1'b0;
    total++; if (mem_cs !== 1'b0 || dtack !== 1'b0) begin bad++;
      $display("FAIL abort_drop got cs=%b dtack=%b exp cs=0 dtack=0", mem_cs, dtack); end
    mem_ok = 1'b1; cen_step(); mem_ok = 1'b0; cen_step();
    total++; if (dtack !== 1'b0 || mem_cs !== 1'b0 || berr !== 1'b0) begin bad++;
      $display("FAIL abort_late_ok got dtack=%b cs=%b berr=%b exp 0 0 0", dtack, mem_cs, berr); end
    run_access(24'h000050, 1'b0, 8'h00, 8'hC3, 1, 10, dc, cc, sl, as_s, wes, wds, ov);
    total++; if (dc !== exp_dtack_cen(0, 1'b0, 1) || cpu_din !== 8'hC3) begin bad++;
      $display("FAIL abort_next_read got dtack=%0d din=%h exp dtack=%0d din=c3", dc, cpu_din, exp_dtack_cen(0, 1'b0, 1)); end
    release_bus();
  endtask

  task automatic test_back_to_back();
    run_access(24'h000060, 1'b0, 8'h00, 8'hA5, 0, 10, dc, cc, sl, as_s, wes, wds, ov);
    as = 1'b0; cen_step();
    total++; if (dtack !== 1'b0) begin bad++; $display("FAIL b2b_release got=%b exp=0", dtack); end
    as = 1'b1; addr = 24'h000061; cen_step(); cen_step();
    total++; if (mem_cs !== 1'b0 || dtack !== 1'b0) begin bad++;
      $display("FAIL b2b_not_armed got cs=%b dtack=%b exp 0 0", mem_cs, dtack); end
    as = 1'b0; cen_step();
    run_access(24'h000061, 1'b0, 8'h00, 8'h6B, 0, 10, dc, cc, sl, as_s, wes, wds, ov);
    total++; if (dc !== 2 || cpu_din !== 8'h6B) begin bad++;
      $display("FAIL b2b_second got dtack=%0d din=%h exp dtack=2 din=6b", dc, cpu_din); end
    release_bus();
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic w;
    logic [7:0] wd, rd, model_din, exp_din;
    int rg, ok;
    model_din = cpu_din;
    gap_en = 1'b1;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 2))
        0:       a = 24'($urandom_range(0, 8191));
        1:       a = 24'h008000 | 24'($urandom_range(0, 32767));
        default: a = 24'h400000 | 24'($urandom_range(0, 24'h3FFFFF));
      endcase
      w = 1'($urandom_range(0, 1));
      wd = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      ok = $urandom_range(0, 2);
      rg = exp_region(a);
      if (rg == 2)  model_din = 8'hFF;
      else if (!w)  model_din = rd;
      exp_q.push_back(model_din);
      run_access(a, w, wd, rd, ok, 12, dc, cc, sl, as_s, wes, wds, ov);
      total++; if (dc !== exp_dtack_cen(rg, w, ok)) begin bad++;
        $display("FAIL rnd_dtack it=%0d a=%h got=%0d exp=%0d", it, a, dc, exp_dtack_cen(rg, w, ok)); end
      total++; if (cc !== exp_cs_cen(rg, w)) begin bad++;
        $display("FAIL rnd_cs it=%0d a=%h got=%0d exp=%0d", it, a, cc, exp_cs_cen(rg, w)); end
      exp_din = exp_q.pop_front();
      total++; if (cpu_din !== exp_din) begin bad++;
        $display("FAIL rnd_din it=%0d a=%h got=%h exp=%h", it, a, cpu_din, exp_din); end
      if (cc > 0) begin
        total++; if ({sl, as_s, wes, wds} !== {rg == 1, a, w, wd}) begin bad++;
          $display("FAIL rnd_req it=%0d got sel=%b addr=%h we=%b wd=%h exp sel=%b addr=%h we=%b wd=%h",
                   it, sl, as_s, wes, wds, rg == 1, a, w, wd); end
      end
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL rnd_overlap it=%0d got=%b exp=0", it, ov); end
      release_bus();
    end
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL rnd_berr got=%b exp=0", berr); end
    gap_en = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    as = 1'b1; addr = 24'h000070; we = 1'b0; mem_rdata = 8'h42;
    cen_step();
    total++; if (mem_cs !== 1'b1) begin bad++; $display("FAIL rst_pre_cs got=%b exp=1", mem_cs); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({mem_cs, dtack, berr, mem_addr} !== 27'd0 || cpu_din !== 8'hFF) begin bad++;
      $display("FAIL rst_async got cs=%b dtack=%b berr=%b addr=%h din=%h exp 0 0 0 000000 ff",
               mem_cs, dtack, berr, mem_addr, cpu_din); end
    as = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    release_bus();
    run_access(24'h000070, 1'b0, 8'h00, 8'h42, 0, 10, dc, cc, sl, as_s, wes, wds, ov);
    total++; if (dc !== 2 || cpu_din !== 8'h42) begin bad++;
      $display("FAIL rst_next_read got dtack=%0d din=%h exp dtack=2 din=42", dc, cpu_din); end
    release_bus();
  endtask

  initial begin
    total = 0; bad = 0; gap_en = 1'b0;
    rst_n = 1'b0; cen = 1'b0; as = 1'b0; we = 1'b0; addr = 24'd0;
    cpu_dout = 8'd0; mem_rdata = 8'd0; mem_ok = 1'b0; berr_clr = 1'b0;
    test_reset();
    test_ram_read();
    test_rom();
    test_open_bus();
    test_timeout();
    test_pending();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
